// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_ctrl
// Purpose  : EX operand forwarding selects plus load-use stall and branch-flush
//            strobes for a 5-stage pipeline. Optional perf counters are enabled
//            by defining HAZ_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forward_ctrl #(
  parameter int RA_W = 5
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic [RA_W-1:0] id_dst,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            ex_branch_taken,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state;
  logic            ex_rw;
  logic            ex_mr;
  logic [RA_W-1:0] ex_dst;
  logic            mem_rw;
  logic [RA_W-1:0] mem_dst;
  logic            load_use;
  logic            stall_hit;
  logic [1:0]      sel_a;
  logic [1:0]      sel_b;

  // Selects are judged one stage ahead: the instruction now in EX will sit in
  // EX/MEM when the ID instruction reaches EX.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src);
    if (src != '0 && ex_rw && ex_dst == src && !ex_mr)
      fwd_sel = 2'b10;
    else if (src != '0 && mem_rw && mem_dst == src)
      fwd_sel = 2'b01;
    else
      fwd_sel = 2'b00;
  endfunction

  assign sel_a = fwd_sel(id_rs);
  assign sel_b = fwd_sel(id_rt);

  // STALL is exactly one cycle; the bubble it inserts already masks the load,
  // the state term just makes that explicit.
  assign load_use = id_valid && ex_mr && ex_rw && (ex_dst != '0) &&
                    (ex_dst == id_rs || ex_dst == id_rt) && (state != STALL);
  assign stall_hit = load_use && !ex_branch_taken;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      ex_rw   <= 1'b0;
      ex_mr   <= 1'b0;
      ex_dst  <= '0;
      mem_rw  <= 1'b0;
      mem_dst <= '0;
      fwd_a   <= 2'b00;
      fwd_b   <= 2'b00;
    end else begin
      mem_rw  <= ex_rw;
      mem_dst <= ex_dst;
      if (idex_bubble || !id_valid) begin
        ex_rw  <= 1'b0;
        ex_mr  <= 1'b0;
        ex_dst <= '0;
        fwd_a  <= 2'b00;
        fwd_b  <= 2'b00;
      end else begin
        ex_rw  <= id_regwrite;
        ex_mr  <= id_memread;
        ex_dst <= id_dst;
        fwd_a  <= sel_a;
        fwd_b  <= sel_b;
      end
      case (state)
        RUN, FLUSH: begin
          if (ex_branch_taken)
            state <= FLUSH;
          else if (load_use)
            state <= STALL;
          else
            state <= RUN;
        end
        STALL:   state <= ex_branch_taken ? FLUSH : RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_hit)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_branch_taken)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_stall_hit;
  assign unused_stall_hit = stall_hit;
`endif

endmodule
`default_nettype wire
